// File: rtl/fifo_pkg.sv
// ============================================================================
// Module : fifo_pkg
// Brief  : Width helpers shared by the ring FIFO and its storage array.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package fifo_pkg;

  // Pointer width; a depth of 1 still needs one address bit.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Occupancy width: must represent 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_ram.sv
// ============================================================================
// Module : fifo_ram
// Brief  : DATA_WIDTH x FIFO_DEPTH array, one synchronous write port and one
//          asynchronous read port. Contents are not reset.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fifo_ram
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           we_i,
  input  logic [ptr_w(FIFO_DEPTH)-1:0]   waddr_i,
  input  logic [DATA_WIDTH-1:0]          wdata_i,
  input  logic [ptr_w(FIFO_DEPTH)-1:0]   raddr_i,
  output logic [DATA_WIDTH-1:0]          rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

`default_nettype wire

// File: rtl/fifo_ring.sv
// ============================================================================
// Module : fifo_ring
// Brief  : Circular-buffer FIFO with occupancy, watermark and sticky error
//          flags. Define FIFO_FWFT_EN for first-word-fall-through reads;
//          otherwise reads are registered (data one cycle after rd_en).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fifo_ring
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int FIFO_DEPTH    = 4,
  parameter int AFULL_THRESH  = FIFO_DEPTH - 1,
  parameter int AEMPTY_THRESH = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wr_en,
  input  logic [DATA_WIDTH-1:0]         wr_data,
  output logic                          wr_ready,
  input  logic                          rd_en,
  output logic [DATA_WIDTH-1:0]         rd_data,
  output logic                          rd_val,
  output logic [cnt_w(FIFO_DEPTH)-1:0]  count,
  output logic                          almost_full,
  output logic                          almost_empty,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int PW = ptr_w(FIFO_DEPTH);
  localparam int CW = cnt_w(FIFO_DEPTH);

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  empty, wr_acc, rd_acc;
  logic [DATA_WIDTH-1:0] ram_rdata;

  // Status depends only on the registered count, never on same-cycle reads.
  assign empty        = (count_q == '0);
  assign wr_ready     = (count_q != CW'(FIFO_DEPTH));
  assign almost_full  = (int'(count_q) >= AFULL_THRESH);
  assign almost_empty = (int'(count_q) <= AEMPTY_THRESH);
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  assign wr_acc = wr_en & wr_ready;
  assign rd_acc = rd_en & ~empty;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q  | (wr_en & ~wr_ready);
    underflow_d = underflow_q | (rd_en & empty);
    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_ram (
    .clk     (clk),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (ram_rdata)
  );

`ifdef FIFO_FWFT_EN
  // Head entry is always visible; gated so reset clears rd_data at once.
  assign rd_val  = ~empty;
  assign rd_data = empty ? '0 : ram_rdata;
`else
  logic                  rd_val_q, rd_val_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

  always_comb begin
    rd_val_d  = rd_acc;
    rd_data_d = rd_data_q;
    if (rd_acc) begin
      rd_data_d = ram_rdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_val_q  <= 1'b0;
      rd_data_q <= '0;
    end else begin
      rd_val_q  <= rd_val_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_val  = rd_val_q;
  assign rd_data = rd_data_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fifo_ring.sv
// ============================================================================
// Module : tb_fifo_ring
// Brief  : Self-checking bench for fifo_ring (either read mode, selected by
//          FIFO_FWFT_EN) against a queue-based reference model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fifo_ring;

  localparam int DW = 8;
  localparam int D  = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_ready, rd_val, almost_full, almost_empty, overflow, underflow;
  logic [DW-1:0] rd_data;
  logic [2:0]    count;

  always #5 clk = ~clk;

  fifo_ring #(
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (D)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .wr_ready     (wr_ready),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rd_val       (rd_val),
    .count        (count),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: a plain queue plus the expected read-port view.
  logic [DW-1:0] mq[$];
  bit            m_val;
  logic [DW-1:0] m_data;
  bit            m_ovf, m_unf;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_val  = 1'b0;
    m_data = '0;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
  endtask

  task automatic model_step(input bit we, input logic [DW-1:0] wd, input bit re);
    bit full, emp, racc, wacc;
    full  = (mq.size() == D);
    emp   = (mq.size() == 0);
    racc  = re && !emp;
    wacc  = we && !full;
    m_ovf = m_ovf | (we && full);
    m_unf = m_unf | (re && emp);
`ifndef FIFO_FWFT_EN
    m_val = racc;
    if (racc) m_data = mq[0];
`endif
    if (racc) void'(mq.pop_front());
    if (wacc) mq.push_back(wd);
`ifdef FIFO_FWFT_EN
    m_val = (mq.size() != 0);
    if (m_val) m_data = mq[0];
`endif
  endtask

  task automatic check_model(input string tag);
    int n;
    n = mq.size();
    chk({tag, ".count"},     {29'd0, count},  n);
    chk({tag, ".wr_ready"},  wr_ready,        (n < D));
    chk({tag, ".afull"},     almost_full,     (n >= D - 1));
    chk({tag, ".aempty"},    almost_empty,    (n <= 1));
    chk({tag, ".overflow"},  overflow,        m_ovf);
    chk({tag, ".underflow"}, underflow,       m_unf);
    chk({tag, ".rd_val"},    rd_val,          m_val);
    if (m_val) chk({tag, ".rd_data"}, rd_data, m_data);
  endtask

  // One clock: drive inputs just after an edge, check just after the next.
  task automatic cycle(input string tag, input bit we, input logic [DW-1:0] wd, input bit re);
    wr_en   = we;
    wr_data = wd;
    rd_en   = re;
    model_step(we, wd, re);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    check_model(tag);
  endtask

  typedef struct {
    bit            we;
    logic [DW-1:0] wd;
    bit            re;
    int            exp_count;
    bit            exp_ovf;
    bit            exp_unf;
    bit            chk_rd;
    logic [DW-1:0] exp_rd;
  } vec_t;

  vec_t tv[20];

  initial begin
    tv[0]  = '{1'b1, 8'd0,  1'b0, 1, 1'b0, 1'b0, 1'b0, 8'd0};
    tv[1]  = '{1'b1, 8'd1,  1'b0, 2, 1'b0, 1'b0, 1'b0, 8'd0};
    tv[2]  = '{1'b1, 8'd2,  1'b0, 3, 1'b0, 1'b0, 1'b0, 8'd0};
    tv[3]  = '{1'b1, 8'd3,  1'b0, 4, 1'b0, 1'b0, 1'b0, 8'd0};
    tv[4]  = '{1'b1, 8'd9,  1'b0, 4, 1'b1, 1'b0, 1'b0, 8'd0};
    tv[5]  = '{1'b0, 8'd0,  1'b1, 3, 1'b1, 1'b0, 1'b1, 8'd0};
    tv[6]  = '{1'b0, 8'd0,  1'b1, 2, 1'b1, 1'b0, 1'b1, 8'd1};
    tv[7]  = '{1'b0, 8'd0,  1'b1, 1, 1'b1, 1'b0, 1'b1, 8'd2};
    tv[8]  = '{1'b0, 8'd0,  1'b1, 0, 1'b1, 1'b0, 1'b1, 8'd3};
    tv[9]  = '{1'b0, 8'd0,  1'b1, 0, 1'b1, 1'b1, 1'b0, 8'd0};
    tv[10] = '{1'b1, 8'd20, 1'b0, 1, 1'b1, 1'b1, 1'b0, 8'd0};
    tv[11] = '{1'b1, 8'd21, 1'b0, 2, 1'b1, 1'b1, 1'b0, 8'd0};
    tv[12] = '{1'b1, 8'd10, 1'b1, 2, 1'b1, 1'b1, 1'b1, 8'd20};
    tv[13] = '{1'b1, 8'd11, 1'b1, 2, 1'b1, 1'b1, 1'b1, 8'd21};
    tv[14] = '{1'b1, 8'd12, 1'b1, 2, 1'b1, 1'b1, 1'b1, 8'd10};
    tv[15] = '{1'b1, 8'd13, 1'b1, 2, 1'b1, 1'b1, 1'b1, 8'd11};
    tv[16] = '{1'b1, 8'd14, 1'b1, 2, 1'b1, 1'b1, 1'b1, 8'd12};
    tv[17] = '{1'b1, 8'd15, 1'b1, 2, 1'b1, 1'b1, 1'b1, 8'd13};
    tv[18] = '{1'b0, 8'd0,  1'b1, 1, 1'b1, 1'b1, 1'b1, 8'd14};
    tv[19] = '{1'b0, 8'd0,  1'b1, 0, 1'b1, 1'b1, 1'b1, 8'd15};

    // Reset state while reset is held, before any clock edge.
    model_reset();
    #2;
    chk("reset.count",    {29'd0, count}, 0);
    chk("reset.wr_ready", wr_ready,       1);
    chk("reset.aempty",   almost_empty,   1);
    chk("reset.afull",    almost_full,    0);
    chk("reset.rd_val",   rd_val,         0);
    chk("reset.ovf",      overflow,       0);
    chk("reset.unf",      underflow,      0);
    #5;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Directed table: fill, overflow, drain in order, underflow, wrap pairs.
    for (int i = 0; i < 20; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
`ifdef FIFO_FWFT_EN
      if (tv[i].chk_rd) begin
        chk({tag, ".head"},     rd_data, tv[i].exp_rd);
        chk({tag, ".head_val"}, rd_val,  1);
      end
`endif
      cycle(tag, tv[i].we, tv[i].wd, tv[i].re);
      chk({tag, ".tcount"}, {29'd0, count}, tv[i].exp_count);
      chk({tag, ".tovf"},   overflow,       tv[i].exp_ovf);
      chk({tag, ".tunf"},   underflow,      tv[i].exp_unf);
`ifndef FIFO_FWFT_EN
      if (tv[i].chk_rd) chk({tag, ".rdata"}, rd_data, tv[i].exp_rd);
      chk({tag, ".trval"}, rd_val, tv[i].chk_rd);
`endif
    end

    // Asynchronous reset mid-stream with count=3, away from any edge.
    cycle("pre_rst0", 1'b1, 8'd30, 1'b0);
    cycle("pre_rst1", 1'b1, 8'd31, 1'b0);
    cycle("pre_rst2", 1'b1, 8'd32, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk("arst.count",    {29'd0, count}, 0);
    chk("arst.rd_val",   rd_val,         0);
    chk("arst.rd_data",  rd_data,        0);
    chk("arst.ovf",      overflow,       0);
    chk("arst.unf",      underflow,      0);
    chk("arst.wr_ready", wr_ready,       1);
    chk("arst.aempty",   almost_empty,   1);
    model_reset();
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Write 5 into an empty FIFO; observe read-mode-specific latency.
    cycle("w5", 1'b1, 8'd5, 1'b0);
`ifdef FIFO_FWFT_EN
    chk("w5.fwft_val",  rd_val,  1);
    chk("w5.fwft_data", rd_data, 5);
    cycle("w5.pop", 1'b0, 8'd0, 1'b1);
    chk("w5.after_pop", rd_val, 0);
`else
    chk("w5.reg_noval", rd_val, 0);
    cycle("w5.idle", 1'b0, 8'd0, 1'b0);
    chk("w5.idle_val", rd_val, 0);
    cycle("w5.rd", 1'b0, 8'd0, 1'b1);
    chk("w5.reg_val",  rd_val,  1);
    chk("w5.reg_data", rd_data, 5);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      bit we, re;
      we = ($urandom_range(0, 99) < 55);
      re = ($urandom_range(0, 99) < 50);
      cycle($sformatf("rnd%0d", i), we, DW'($urandom), re);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fifo_ring.md
FIFO_RING -- requirements
Module: fifo_ring

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, payload width in bits.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, number of entries; power of two, at least 2.
REQ-003 SHALL have parameter AFULL_THRESH, default FIFO_DEPTH-1, count at or above which almost_full asserts.
REQ-004 SHALL have parameter AEMPTY_THRESH, default 1, count at or below which almost_empty asserts.
REQ-005 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-006 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-007 SHALL have port wr_en, input, 1, write request.
REQ-008 SHALL have port wr_data, input, DATA_WIDTH, write payload.
REQ-009 SHALL have port wr_ready, output, 1, high when count < FIFO_DEPTH.
REQ-010 SHALL have port rd_en, input, 1, read request.
REQ-011 SHALL have port rd_data, output, DATA_WIDTH, read payload.
REQ-012 SHALL have port rd_val, output, 1, rd_data valid.
REQ-013 SHALL have port count, output, $clog2(FIFO_DEPTH)+1, current occupancy 0..FIFO_DEPTH.
REQ-014 SHALL have port almost_full, output, 1, count >= AFULL_THRESH.
REQ-015 SHALL have port almost_empty, output, 1, count <= AEMPTY_THRESH.
REQ-016 SHALL have port overflow, output, 1, sticky: write attempted while full.
REQ-017 SHALL have port underflow, output, 1, sticky: read attempted while empty.

Function
REQ-018 SHALL store entries in a circular RAM array addressed by wr_ptr/rd_ptr of $clog2(FIFO_DEPTH) bits; no data shifting.
REQ-019 SHALL accept a write when wr_en && wr_ready; wr_ptr advances by one, wrapping FIFO_DEPTH-1 -> 0.
REQ-020 SHALL accept a read when rd_en && count != 0; rd_ptr advances by one, same wrap rule.
REQ-021 SHALL compute wr_ready solely from registered count; it does not depend on rd_en in the same cycle.
REQ-022 SHALL update count by +1 (write only), -1 (read only), 0 (both accepted or neither).
REQ-023 SHALL, on simultaneous wr_en and rd_en when full, accept only the read; count becomes FIFO_DEPTH-1; overflow sets.
REQ-024 SHALL, on simultaneous wr_en and rd_en when empty (registered mode), accept only the write; underflow sets.
REQ-025 SHALL drop the payload of a refused write and leave memory, pointers and count unchanged.
REQ-026 SHALL keep overflow and underflow set until reset.
REQ-027 SHALL derive almost_full, almost_empty, wr_ready combinationally from registered count.

Reset
REQ-028 SHALL, on reset high, immediately clear wr_ptr, rd_ptr, count, rd_val, rd_data, overflow, underflow, independent of clk.
REQ-029 SHALL present after reset: wr_ready=1, almost_empty=1, almost_full=0 (for AFULL_THRESH>0), count=0.
REQ-030 SHALL discard all stored entries on reset asserted mid-operation; memory contents need not be cleared.

Configuration
REQ-031 SHALL support macro FIFO_FWFT_EN selecting read mode.
REQ-032 SHALL, without FIFO_FWFT_EN, register reads: accepted read in cycle N gives rd_data and rd_val=1 in cycle N+1; rd_val=0 in cycles after no accepted read.
REQ-033 SHALL, with FIFO_FWFT_EN, show the head entry on rd_data with rd_val = (count != 0) in the same cycle; rd_en pops it; a write into an empty FIFO appears on rd_data one cycle after acceptance.

Structure
REQ-034 SHALL place the count-width and pointer-width helper constants in shared package fifo_pkg.
REQ-035 SHALL instantiate storage as sub-module fifo_ram (one write port, one asynchronous read port, DATA_WIDTH x FIFO_DEPTH).

Verification
REQ-036 SHALL cover: DEPTH=4, write 0,1,2,3 -> count=4, wr_ready=0, almost_full=1; read four -> data 0,1,2,3 in order.
REQ-037 SHALL cover: full FIFO, write 9 -> overflow=1, count stays 4, later reads never return 9.
REQ-038 SHALL cover: empty FIFO, rd_en=1 -> underflow=1, rd_val=0, count stays 0.
REQ-039 SHALL cover: six write/read pairs of 10..15 at count=2 -> count constant 2, pointers wrap, output order preserved.
REQ-040 SHALL cover: reset asserted mid-stream with count=3, off clock edge -> count=0, rd_val=0, flags clear immediately.
REQ-041 SHALL cover: both builds -> write 5 into empty FIFO; FWFT rd_data=5/rd_val=1 next cycle without rd_en; registered needs rd_en, data one cycle later.
